// File: rtl/spi_gpio_pkg.sv
// Shared constants and frame-state type for the SPI GPIO extender.
package spi_gpio_pkg;

    localparam int unsigned DEFAULT_NUM_REGS  = 8;
    localparam logic [7:0]  DEFAULT_DEVICE_ID = 8'h5A;
    localparam int unsigned REG_LED           = 0;
    localparam int unsigned CMD_WRITE_BIT     = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } frame_state_t;

    // The read-only ID register always sits at the last address.
    function automatic int unsigned reg_id(input int unsigned num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/spi_gpio_extender_top_spi_slave_if.sv
// Oversampled mode-3 SPI slave: pin synchronizers, edge detection, byte framing
// and the MSB-first shift-in/shift-out registers.
module spi_slave_if
    import spi_gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sck,
    input  logic       i_ssel,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_first,
    output logic       o_frame_start,
    output logic       o_frame_end,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_load
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ssel_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_ssel_d;

    frame_state_t r_state;
    logic [2:0]   r_cnt;
    logic [6:0]   r_shift;
    logic [7:0]   r_tx;
    logic         r_miso;
    logic         r_rx_valid;
    logic [7:0]   r_rx_byte;
    logic         r_rx_first;
    logic         r_frame_start;
    logic         r_frame_end;

    logic         w_sck;
    logic         w_ssel;
    logic         w_mosi;
    logic         w_sck_rise;
    logic         w_sck_fall;
    logic         w_ssel_fall;
    logic         w_ssel_rise;
    logic         w_bit_take;
    frame_state_t w_state_base;
    logic [2:0]   w_cnt_base;

    assign w_sck       = r_sck_sync[SYNC_STAGES-1];
    assign w_ssel      = r_ssel_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise  = w_sck & ~r_sck_d;
    assign w_sck_fall  = ~w_sck & r_sck_d;
    assign w_ssel_fall = ~w_ssel & r_ssel_d;
    assign w_ssel_rise = w_ssel & ~r_ssel_d;

    // A frame restart seen in the same cycle as an SCK rise counts that bit
    // as bit 0 of the new command byte.
    always_comb begin
        w_state_base = w_ssel_fall ? ST_CMD : r_state;
        w_cnt_base   = w_ssel_fall ? 3'd0 : r_cnt;
    end

    assign w_bit_take = w_sck_rise & ~w_ssel & (w_state_base != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_sync    <= '1;
            r_ssel_sync   <= '1;
            r_mosi_sync   <= '0;
            r_sck_d       <= 1'b1;
            r_ssel_d      <= 1'b1;
            r_state       <= ST_CMD;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_tx          <= '0;
            r_miso        <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_rx_byte     <= '0;
            r_rx_first    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            r_sck_sync    <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ssel_sync   <= {r_ssel_sync[SYNC_STAGES-2:0], i_ssel};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_d       <= w_sck;
            r_ssel_d      <= w_ssel;
            r_rx_valid    <= 1'b0;
            r_frame_start <= w_ssel_fall;
            r_frame_end   <= w_ssel_rise;

            if (w_ssel_rise) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (w_ssel_fall) begin
                r_state <= ST_CMD;
                r_cnt   <= '0;
            end

            if (w_bit_take) begin
                r_shift <= {r_shift[5:0], w_mosi};
                if (w_cnt_base == 3'd7) begin
                    r_rx_valid <= 1'b1;
                    r_rx_byte  <= {r_shift, w_mosi};
                    r_rx_first <= (w_state_base == ST_CMD);
                    r_state    <= ST_DATA;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= w_cnt_base + 3'd1;
                end
            end

            if (w_ssel) begin
                r_miso <= 1'b0;
                r_tx   <= '0;
            end else if (w_sck_fall) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end else if (i_tx_load) begin
                r_tx <= i_tx_byte;
            end
        end
    end

    assign o_miso        = r_miso;
    assign o_rx_valid    = r_rx_valid;
    assign o_rx_byte     = r_rx_byte;
    assign o_rx_first    = r_rx_first;
    assign o_frame_start = r_frame_start;
    assign o_frame_end   = r_frame_end;

endmodule

// File: rtl/spi_gpio_extender_top.sv
// GPIO extender top: SPI slave front end, 8-bit register file with
// auto-incrementing address, read-only device ID and user LED.
module spi_gpio_extender_top
    import spi_gpio_pkg::*;
#(
    parameter int unsigned NUM_REGS    = DEFAULT_NUM_REGS,
    parameter logic [7:0]  DEVICE_ID   = DEFAULT_DEVICE_ID,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    output logic LED,
    input  logic PIN_10,
    input  logic PIN_11,
    input  logic PIN_12,
    output logic PIN_13
);

    localparam int unsigned AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned REG_ID    = reg_id(NUM_REGS);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_REGS - 1);

    logic          w_rx_valid;
    logic [7:0]    w_rx_byte;
    logic          w_rx_first;
    logic          w_frame_start;
    logic          w_frame_end;
    logic [AW-1:0] w_cmd_addr;
    logic [AW-1:0] w_addr_next;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_tx_byte;

    logic [7:0]    r_regs [NUM_REGS];
    logic [AW-1:0] r_addr;
    logic          r_write;

    spi_slave_if #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .i_clk         (CLK),
        .i_rst_n       (RST_N),
        .i_sck         (PIN_10),
        .i_ssel        (PIN_11),
        .i_mosi        (PIN_12),
        .o_miso        (PIN_13),
        .o_rx_valid    (w_rx_valid),
        .o_rx_byte     (w_rx_byte),
        .o_rx_first    (w_rx_first),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end),
        .i_tx_byte     (w_tx_byte),
        .i_tx_load     (w_rx_valid)
    );

    assign w_cmd_addr  = AW'(32'(w_rx_byte[6:0]) % NUM_REGS);
    assign w_addr_next = (r_addr == ADDR_LAST) ? '0 : r_addr + AW'(1);
    // Preload the byte for the next slot: the command's start address, or
    // the address following the byte that just completed.
    assign w_rd_addr   = w_rx_first ? w_cmd_addr : w_addr_next;
    assign w_tx_byte   = r_regs[w_rd_addr];
    assign LED         = r_regs[REG_LED][0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == REG_ID) ? DEVICE_ID : '0;
            end
        end else begin
            if (w_frame_start || w_frame_end) begin
                r_write <= 1'b0;
            end
            if (w_frame_start) begin
                r_addr <= '0;
            end
            if (w_rx_valid) begin
                if (w_rx_first) begin
                    r_write <= w_rx_byte[CMD_WRITE_BIT];
                    r_addr  <= w_cmd_addr;
                end else begin
                    if (r_write) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (i != REG_ID && r_addr == AW'(i)) begin
                                r_regs[i] <= w_rx_byte;
                            end
                        end
                    end
                    r_addr <= w_addr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_gpio_extender_top.sv
// Scoreboard bench for the SPI GPIO extender: a high-level register model
// predicts MISO bytes; a separate monitor decodes MISO and compares.
`timescale 1ns/1ps
module tb_spi_gpio_extender_top;

    localparam int         NREGS = 8;
    localparam logic [7:0] ID    = 8'h5A;
    localparam int         HALF  = 16;

    logic CLK    = 1'b0;
    logic RST_N  = 1'b0;
    logic PIN_10 = 1'b1;
    logic PIN_11 = 1'b1;
    logic PIN_12 = 1'b0;
    logic LED;
    logic PIN_13;

    always #31 CLK = ~CLK;

    spi_gpio_extender_top #(
        .NUM_REGS    (NREGS),
        .DEVICE_ID   (ID),
        .SYNC_STAGES (2)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .LED    (LED),
        .PIN_10 (PIN_10),
        .PIN_11 (PIN_11),
        .PIN_12 (PIN_12),
        .PIN_13 (PIN_13)
    );

    typedef struct {
        bit         chk;
        logic [7:0] val;
    } exp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem [NREGS];
    exp_t       exp_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mem[i] = (i == NREGS - 1) ? ID : 8'h00;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Mode 3: data changes on the falling edge; returns right after the last rise.
    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            PIN_10 = 1'b0;
            PIN_12 = b[i];
            wait_clk(HALF);
            PIN_10 = 1'b1;
            if (i != lo) wait_clk(HALF);
        end
    endtask

    // Data byte k (0-based) sits at d[8*k +: 8].
    task automatic spi_frame(input logic [7:0] cmd, input int n, input logic [63:0] d, input bit coin);
        int         start;
        int         addr;
        logic [7:0] b;
        exp_t       e;
        start = int'(cmd[6:0]) % NREGS;
        if (coin) begin
            PIN_10 = 1'b0;
            PIN_12 = cmd[7];
            wait_clk(HALF);
            PIN_11 = 1'b0;
            PIN_10 = 1'b1;
            wait_clk(HALF);
            send_bits(cmd, 6, 0);
        end else begin
            PIN_11 = 1'b0;
            wait_clk(HALF);
            send_bits(cmd, 7, 0);
        end
        for (int k = 0; k < n; k++) begin
            addr  = (start + k) % NREGS;
            b     = d[8*k +: 8];
            e.chk = !cmd[7];
            e.val = cmd[7] ? 8'h00 : mem[addr];
            exp_q.push_back(e);
            wait_clk(HALF);
            send_bits(b, 7, 0);
            if (cmd[7] && addr != NREGS - 1) mem[addr] = b;
        end
        if (cmd[7] && n > 0) begin
            wait_clk(4);
            check("led_after_write", {7'b0, LED}, {7'b0, mem[0][0]});
            wait_clk(HALF - 4);
        end else begin
            wait_clk(HALF);
        end
        PIN_11 = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic spi_partial(input logic [7:0] cmd, input logic [7:0] data, input int nbits);
        PIN_11 = 1'b0;
        wait_clk(HALF);
        send_bits(cmd, 7, 0);
        wait_clk(HALF);
        send_bits(data, 7, 8 - nbits);
        wait_clk(HALF);
    endtask

    // Monitor: decodes MISO at each SCK rise and checks every data byte.
    logic [7:0] mon_sh    = 8'h00;
    int         mon_bits  = 0;
    int         mon_bytes = 0;
    logic       mon_ps    = 1'b1;
    logic       mon_pk    = 1'b1;
    exp_t       mon_e;

    initial begin
        forever begin
            @(PIN_10 or PIN_11);
            if (PIN_11 !== mon_ps) begin
                mon_bits  = 0;
                mon_bytes = 0;
                mon_ps    = PIN_11;
            end
            if (!PIN_11 && PIN_10 && !mon_pk) begin
                mon_sh = {mon_sh[6:0], PIN_13};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    if (mon_bytes > 0) begin
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_underflow: got byte %02h with no expectation queued", mon_sh);
                        end else begin
                            n_tests--;
                            mon_e = exp_q.pop_front();
                            if (mon_e.chk) check("miso_byte", mon_sh, mon_e.val);
                        end
                    end
                    mon_bytes++;
                end
            end
            mon_pk = PIN_10;
        end
    end

    initial begin
        #(62 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        wait_clk(3);
        check("rst_led", {7'b0, LED}, 8'h00);
        check("rst_miso", {7'b0, PIN_13}, 8'h00);
        RST_N = 1'b1;
        wait_clk(4);

        spi_frame(8'h07, 1, 64'h0, 1'b0);
        spi_frame(8'h80, 1, 64'h01, 1'b0);
        spi_frame(8'h80, 3, 64'h00_00_CC, 1'b0);
        spi_frame(8'h00, 3, 64'h0, 1'b0);
        spi_frame(8'h86, 3, 64'h33_22_11, 1'b0);
        spi_frame(8'h06, 3, 64'h0, 1'b0);
        spi_frame(8'h81, 1, 64'hA3, 1'b0);
        spi_frame(8'h01, 1, 64'h00, 1'b0);

        spi_partial(8'h80, 8'hFF, 4);
        PIN_11 = 1'b1;
        wait_clk(2 * HALF);
        spi_frame(8'h00, 2, 64'h0, 1'b0);

        spi_frame(8'h80, 0, 64'h0, 1'b0);
        spi_frame(8'h00, 8, 64'h0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            PIN_12 = 1'($urandom);
            PIN_10 = ~PIN_10;
            wait_clk(HALF);
        end
        PIN_10 = 1'b1;
        wait_clk(HALF);
        spi_frame(8'h82, 1, 64'h77, 1'b1);
        spi_frame(8'h02, 1, 64'h0, 1'b0);

        spi_frame(8'h80, 1, 64'hFF, 1'b0);
        spi_partial(8'h80, 8'hFF, 4);
        RST_N = 1'b0;
        #1;
        check("midframe_rst_led", {7'b0, LED}, 8'h00);
        check("midframe_rst_miso", {7'b0, PIN_13}, 8'h00);
        wait_clk(2);
        PIN_11 = 1'b1;
        model_reset();
        wait_clk(4);
        RST_N = 1'b1;
        wait_clk(2 * HALF);
        spi_frame(8'h00, 8, 64'h0, 1'b0);
        spi_frame(8'h80, 1, 64'h01, 1'b0);

        for (int i = 0; i < 20; i++) begin
            spi_frame(8'($urandom), int'($urandom_range(0, 4)),
                      {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end
        spi_frame(8'h00, 8, 64'h0, 1'b0);

        wait_clk(10);
        check("sb_drain", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
